// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between a load/store unit and the data memory controller.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (core load/store unit).
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: one load/store per request, with byte enables and sign/zero extension.
// Latency: the response is valid LATENCY cycles after the request is accepted.
// Backpressure: one request in flight at a time; the response holds until rsp_ready, and only then is a new request accepted.
module data_mem_ctrl #(
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                access;
  logic                bad;
  logic [ADDR_W-1:0]   widx;
  logic [31:0]         word;
  logic [31:0]         shifted;
  logic [15:0]         half;
  logic [31:0]         load_val;
  logic [31:0]         wr_word;
  logic [3:0]          be;

  assign accept = bus.req_valid && (state == IDLE);
  // The single memory access happens on the edge that ends the last WAIT cycle.
  assign access = (state == WAIT) && (cnt == 4'd1);
  // Upper address bits are dropped, so addresses wrap modulo the memory size.
  assign widx   = addr_q[ADDR_W+1:2];
  assign word   = mem[widx];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake/response outputs; response fields read as zero outside RESP.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request at acceptance and count down the access latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY);
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[ADDR_W+1:0];
      wdata_q <= bus.req_wdata;
    end else if (state == WAIT) begin
      cnt     <= cnt - 4'd1;
    end else if (state == IDLE) begin
      cnt     <= 4'd0;
    end
  end

  // Illegal size codes and misaligned halfword/word accesses are rejected.
  always_comb begin
    if (we_q) bad = (f3_q > 3'd2);
    else      bad = (f3_q == 3'd3) || (f3_q == 3'd6) || (f3_q == 3'd7);
    if ((f3_q[1:0] == 2'b01) && addr_q[0])          bad = 1'b1;
    if ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00)) bad = 1'b1;
  end

  // Load extraction: pick the addressed byte/halfword and extend it.
  always_comb begin
    shifted  = word >> {addr_q[1:0], 3'b000};
    half     = addr_q[1] ? word[31:16] : word[15:0];
    load_val = 32'd0;
    case (f3_q)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{half[15]}}, half};
      3'd2:    load_val = word;
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd5:    load_val = {16'd0, half};
      default: load_val = 32'd0;
    endcase
  end

  // Store lane steering: replicate the right-aligned data and enable only the addressed bytes.
  always_comb begin
    be      = 4'b0000;
    wr_word = wdata_q;
    case (f3_q)
      3'd0: begin
        be      = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      3'd1: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Memory array: no reset, so contents survive rst; a reset in WAIT forces IDLE and the write never fires.
  always_ff @(posedge clk) begin
    if (access && we_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Response capture at the access edge; cleared once the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= (we_q || bad) ? 32'd0 : load_val;
      err_q   <= bad;
    end else if ((state == RESP) && bus.rsp_ready) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end
endmodule
